// File: rtl/srt_pre_processing.sv
`default_nettype none
// ============================================================================
// Module      : srt_pre_processing
// Description : Unpacks two IEEE-754 single-precision operands for an SRT
//               divider: special-case decode, mantissa normalization and
//               biased result exponent.
// Revision    : 1.0 - initial release
// ============================================================================
module srt_pre_processing (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [23:0] dividend_mant,
    output logic [23:0] divisor_mant,
    output logic        result_sign,
    output logic [9:0]  exp_out,
    output logic        is_nan,
    output logic        is_inf,
    output logic        is_zero,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_NORM = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [9:0] c_BIAS = 10'd127;

    state_t      state_q, state_d;
    logic [23:0] mant_a_q, mant_a_d;
    logic [23:0] mant_b_q, mant_b_d;
    logic [9:0]  exp_q, exp_d;
    logic        sign_q, sign_d;
    logic        nan_q, nan_d;
    logic        inf_q, inf_d;
    logic        zero_q, zero_d;
    logic        dbz_q, dbz_d;

    // Operand classification
    logic [7:0]  w_ea, w_eb, w_eff_a, w_eff_b;
    logic        w_a_nan, w_a_inf, w_a_zero, w_b_nan, w_b_inf, w_b_zero;
    logic        w_nan, w_inf, w_zero, w_dbz, w_special;
    logic [23:0] w_mant_a, w_mant_b, w_norm_a, w_norm_b;
    logic [9:0]  w_exp;

    assign w_ea     = dividend[30:23];
    assign w_eb     = divisor[30:23];
    assign w_a_nan  = (w_ea == 8'hFF) && (dividend[22:0] != 23'd0);
    assign w_a_inf  = (w_ea == 8'hFF) && (dividend[22:0] == 23'd0);
    assign w_a_zero = (w_ea == 8'h00) && (dividend[22:0] == 23'd0);
    assign w_b_nan  = (w_eb == 8'hFF) && (divisor[22:0] != 23'd0);
    assign w_b_inf  = (w_eb == 8'hFF) && (divisor[22:0] == 23'd0);
    assign w_b_zero = (w_eb == 8'h00) && (divisor[22:0] == 23'd0);

    assign w_nan     = w_a_nan | w_b_nan | (w_a_zero & w_b_zero) | (w_a_inf & w_b_inf);
    assign w_inf     = ~w_nan & (w_a_inf | w_b_zero);
    assign w_dbz     = ~w_nan & w_b_zero & ~w_a_inf;
    assign w_zero    = ~w_nan & (w_a_zero | w_b_inf);
    assign w_special = w_nan | w_inf | w_zero;

    // Subnormals use exponent 1 with no hidden bit
    assign w_eff_a  = (w_ea == 8'h00) ? 8'd1 : w_ea;
    assign w_eff_b  = (w_eb == 8'h00) ? 8'd1 : w_eb;
    assign w_mant_a = {(w_ea != 8'h00), dividend[22:0]};
    assign w_mant_b = {(w_eb != 8'h00), divisor[22:0]};
    assign w_exp    = {2'b00, w_eff_a} - {2'b00, w_eff_b} + c_BIAS;

    assign w_norm_a = mant_a_q[23] ? mant_a_q : {mant_a_q[22:0], 1'b0};
    assign w_norm_b = mant_b_q[23] ? mant_b_q : {mant_b_q[22:0], 1'b0};

    always_comb begin
        state_d  = state_q;
        mant_a_d = mant_a_q;
        mant_b_d = mant_b_q;
        exp_d    = exp_q;
        sign_d   = sign_q;
        nan_d    = nan_q;
        inf_d    = inf_q;
        zero_d   = zero_q;
        dbz_d    = dbz_q;
        case (state_q)
            ST_IDLE: begin
                if (in_valid) begin
                    sign_d = dividend[31] ^ divisor[31];
                    nan_d  = w_nan;
                    inf_d  = w_inf;
                    zero_d = w_zero;
                    dbz_d  = w_dbz;
                    if (w_special) begin
                        mant_a_d = 24'd0;
                        mant_b_d = 24'd0;
                        exp_d    = 10'd0;
                        state_d  = ST_HOLD;
                    end else begin
                        mant_a_d = w_mant_a;
                        mant_b_d = w_mant_b;
                        exp_d    = w_exp;
                        state_d  = (w_mant_a[23] && w_mant_b[23]) ? ST_HOLD : ST_NORM;
                    end
                end
            end
            ST_NORM: begin
                mant_a_d = w_norm_a;
                mant_b_d = w_norm_b;
                exp_d    = exp_q - {9'd0, ~mant_a_q[23]} + {9'd0, ~mant_b_q[23]};
                if (w_norm_a[23] && w_norm_b[23]) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            mant_a_q <= 24'd0;
            mant_b_q <= 24'd0;
            exp_q    <= 10'd0;
            sign_q   <= 1'b0;
            nan_q    <= 1'b0;
            inf_q    <= 1'b0;
            zero_q   <= 1'b0;
            dbz_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            mant_a_q <= mant_a_d;
            mant_b_q <= mant_b_d;
            exp_q    <= exp_d;
            sign_q   <= sign_d;
            nan_q    <= nan_d;
            inf_q    <= inf_d;
            zero_q   <= zero_d;
            dbz_q    <= dbz_d;
        end
    end

    assign in_ready      = (state_q == ST_IDLE);
    assign out_valid     = (state_q == ST_HOLD);
    assign dividend_mant = mant_a_q;
    assign divisor_mant  = mant_b_q;
    assign result_sign   = sign_q;
    assign exp_out       = exp_q;
    assign is_nan        = nan_q;
    assign is_inf        = inf_q;
    assign is_zero       = zero_q;
    assign div_by_zero   = dbz_q;

endmodule
`default_nettype wire

// File: tb/tb_srt_pre_processing.sv
`default_nettype none
// ============================================================================
// Module      : tb_srt_pre_processing
// Description : Self-checking bench for srt_pre_processing with directed
//               corner cases and random operand pairs against a value model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_srt_pre_processing;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] dividend = 32'd0;
    logic [31:0] divisor = 32'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [23:0] dividend_mant;
    logic [23:0] divisor_mant;
    logic        result_sign;
    logic [9:0]  exp_out;
    logic        is_nan, is_inf, is_zero, div_by_zero;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [23:0] ma;
        logic [23:0] mb;
        logic [9:0]  ex;
        logic        sg;
        logic        nan;
        logic        inf;
        logic        zero;
        logic        dbz;
        logic [5:0]  lat;
    } exp_t;

    srt_pre_processing dut (
        .clk           (clk),
        .rst           (rst),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .dividend      (dividend),
        .divisor       (divisor),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .dividend_mant (dividend_mant),
        .divisor_mant  (divisor_mant),
        .result_sign   (result_sign),
        .exp_out       (exp_out),
        .is_nan        (is_nan),
        .is_inf        (is_inf),
        .is_zero       (is_zero),
        .div_by_zero   (div_by_zero)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    // Value-level model: classify operands, count leading zeros arithmetically
    function automatic exp_t model(input logic [31:0] a, input logic [31:0] b);
        exp_t r;
        int ea, eb, fa, fb, ma, mb, la, lb, ex;
        bit an, bn, ai, bi, az, bz;
        r  = '0;
        ea = int'(a[30:23]);
        eb = int'(b[30:23]);
        fa = int'(a[22:0]);
        fb = int'(b[22:0]);
        an = (ea == 255) && (fa != 0);
        bn = (eb == 255) && (fb != 0);
        ai = (ea == 255) && (fa == 0);
        bi = (eb == 255) && (fb == 0);
        az = (ea == 0) && (fa == 0);
        bz = (eb == 0) && (fb == 0);
        r.sg = a[31] ^ b[31];
        if (an || bn || (az && bz) || (ai && bi)) r.nan = 1'b1;
        else if (ai) r.inf = 1'b1;
        else if (bz) begin r.inf = 1'b1; r.dbz = 1'b1; end
        else if (az || bi) r.zero = 1'b1;
        if (r.nan || r.inf || r.zero) begin
            r.lat = 6'd1;
        end else begin
            ma = ((ea == 0) ? 0 : 8388608) + fa;
            mb = ((eb == 0) ? 0 : 8388608) + fb;
            la = 0;
            lb = 0;
            while (ma < 8388608) begin ma = ma * 2; la++; end
            while (mb < 8388608) begin mb = mb * 2; lb++; end
            ex   = ((ea == 0) ? 1 : ea) - ((eb == 0) ? 1 : eb) + 127 - la + lb;
            r.ma = 24'(ma);
            r.mb = 24'(mb);
            r.ex = 10'(ex);
            r.lat = 6'(1 + ((la > lb) ? la : lb));
        end
        return r;
    endfunction

    function automatic logic [31:0] rand_fp();
        logic [7:0]  e;
        logic [22:0] f;
        int k;
        k = int'($urandom_range(0, 9));
        if (k == 0)      e = 8'h00;
        else if (k == 1) e = 8'hFF;
        else             e = 8'($urandom_range(1, 254));
        k = int'($urandom_range(0, 5));
        if (k == 0)      f = 23'd0;
        else if (k == 1) f = 23'($urandom_range(1, 255));
        else             f = 23'($urandom);
        return {1'($urandom), e, f};
    endfunction

    task automatic check_outs(input string tag, input exp_t e);
        chk({tag, ".dividend_mant"}, 32'(dividend_mant), 32'(e.ma));
        chk({tag, ".divisor_mant"},  32'(divisor_mant),  32'(e.mb));
        chk({tag, ".exp_out"},       32'(exp_out),       32'(e.ex));
        chk({tag, ".result_sign"},   32'(result_sign),   32'(e.sg));
        chk({tag, ".flags"}, {28'd0, is_nan, is_inf, is_zero, div_by_zero},
            {28'd0, e.nan, e.inf, e.zero, e.dbz});
    endtask

    task automatic check_reset_state(input string tag);
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd0);
        chk({tag, ".in_ready"},  32'(in_ready),  32'd1);
        chk({tag, ".outputs"},
            {6'd0, dividend_mant, 2'd0} | 32'(divisor_mant) | 32'(exp_out)
                | {28'd0, result_sign, is_nan, is_inf, is_zero} | 32'(div_by_zero),
            32'd0);
    endtask

    // Accept one operand pair, measure latency (accepting edge counts as 1)
    task automatic txn(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input bit release_now);
        exp_t e;
        int lat;
        e = model(a, b);
        @(negedge clk);
        dividend = a;
        divisor  = b;
        in_valid = 1'b1;
        chk({tag, ".in_ready_idle"}, 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        while (out_valid !== 1'b1 && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk({tag, ".latency"},   32'(lat),       32'(e.lat));
        chk({tag, ".out_valid"}, 32'(out_valid), 32'd1);
        chk({tag, ".in_ready_busy"}, 32'(in_ready), 32'd0);
        check_outs(tag, e);
        if (release_now) begin
            @(posedge clk);
            #1;
            chk({tag, ".handshake"}, {30'd0, out_valid, in_ready}, 32'd1);
        end
    endtask

    initial begin
        exp_t e;
        logic [31:0] ra, rb;

        repeat (2) @(posedge clk);
        #1;
        check_reset_state("reset");
        @(negedge clk);
        rst = 1'b0;

        txn("div_6_2",     32'h40C00000, 32'h40000000, 1'b1);
        txn("neg1_div_0",  32'hBF800000, 32'h00000000, 1'b1);
        txn("zero_div_0",  32'h00000000, 32'h80000000, 1'b1);
        txn("inf_div_inf", 32'h7F800000, 32'h7F800000, 1'b1);
        txn("one_div_inf", 32'h3F800000, 32'h7F800000, 1'b1);
        txn("inf_div_0",   32'hFF800000, 32'h00000000, 1'b1);
        txn("nan_div_one", 32'h7FC00001, 32'h3F800000, 1'b1);
        txn("minsub_div1", 32'h00000001, 32'h3F800000, 1'b1);
        txn("one_div_min", 32'h3F800000, 32'h00000001, 1'b1);
        txn("sub_div_sub", 32'h00000003, 32'h00400000, 1'b1);

        // Back-pressure: outputs frozen and new operands ignored while held
        out_ready = 1'b0;
        txn("hold", 32'h3F800000, 32'h00400000, 1'b0);
        e = model(32'h3F800000, 32'h00400000);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = (i % 2) == 0;
            dividend = 32'h40C00000;
            divisor  = 32'hBF800000;
            @(posedge clk);
            #1;
            chk("hold.out_valid", {30'd0, out_valid, in_ready}, 32'd2);
            check_outs("hold", e);
        end
        @(negedge clk);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold.release", {30'd0, out_valid, in_ready}, 32'd1);

        // Reset while normalizing
        @(negedge clk);
        dividend = 32'h00000001;
        divisor  = 32'h3F800000;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("mid_norm.out_valid", 32'(out_valid), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_norm");
        @(negedge clk);
        rst = 1'b0;
        txn("after_rst_norm", 32'h40C00000, 32'h40000000, 1'b1);

        // Reset while holding a result
        out_ready = 1'b0;
        txn("pre_rst_hold", 32'hC1200000, 32'h3E800000, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("reset_hold");
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;

        for (int i = 0; i < 60; i++) begin
            ra = rand_fp();
            rb = rand_fp();
            txn($sformatf("rand%0d", i), ra, rb, 1'b1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
